// File: rtl/fetch_buffer.sv
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : Instruction-fetch front end. Issues line reads on the system
//             bus, fills a circular byte buffer from 64-bit beats (honouring
//             a byte start offset) and presents a sliding decode window.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
   parameter int BUF_BYTES  = 128,
   parameter int LINE_BYTES = 64,
   parameter int WINDOW     = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [63:0]                   entry,
   output logic                          req_cyc,
   output logic [63:0]                   req_addr,
   input  logic                          req_ack,
   input  logic                          resp_cyc,
   input  logic [63:0]                   resp_data,
   output logic                          resp_ack,
   input  logic                          redirect,
   input  logic [63:0]                   redirect_addr,
   output logic                          win_valid,
   output logic [WINDOW*8-1:0]           win_bytes,
   output logic [63:0]                   win_addr,
   input  logic [$clog2(WINDOW+1)-1:0]   consume,
   output logic [$clog2(BUF_BYTES):0]    occupancy
);

   localparam int c_beats  = LINE_BYTES / 8;
   localparam int c_ptr_w  = $clog2(BUF_BYTES);
   localparam int c_occ_w  = c_ptr_w + 1;
   localparam int c_cns_w  = $clog2(WINDOW + 1);
   localparam int c_loff_w = $clog2(LINE_BYTES);
   localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACTIVE = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [7:0]            r_buf [0:BUF_BYTES-1];
   logic [c_ptr_w-1:0]    r_rd, r_wr, w_rd_nxt, w_wr_nxt;
   logic [c_occ_w-1:0]    r_occ, w_occ_nxt;
   logic [c_beat_w-1:0]   r_beat, w_beat_nxt;
   logic [63:0]           r_fetch_line, w_line_nxt;
   logic [c_loff_w-1:0]   r_skip, w_skip_nxt;
   logic [63:0]           r_win_addr, w_win_addr_nxt;
   logic                  r_req_cyc, w_req_cyc_nxt;
   logic [63:0]           r_req_addr, w_req_addr_nxt;

   logic                  w_data_beat;
   logic [31:0]           w_base, w_first;
   logic [3:0]            w_nwr;
   logic [c_cns_w-1:0]    w_cons;
   logic                  w_last;
   logic                  w_req_fire;

   assign req_cyc   = r_req_cyc;
   assign req_addr  = r_req_addr;
   assign resp_ack  = resp_cyc;
   assign win_addr  = r_win_addr;
   assign occupancy = r_occ;
   assign win_valid = (r_occ >= c_occ_w'(WINDOW));

   assign w_req_fire = r_req_cyc && req_ack;
   assign w_last     = (r_beat == c_beat_w'(c_beats - 1));
   // A consume is only honoured when the window is full and no flush is pending.
   assign w_cons     = (win_valid && !redirect) ? consume : '0;

   // Which bytes of the current beat land in the buffer: a suffix starting at w_first.
   always_comb begin
      w_data_beat = resp_cyc && !redirect && (r_state == S_WAIT || r_state == S_ACTIVE);
      w_base      = 32'(r_beat) << 3;
      if (32'(r_skip) >= w_base + 32'd8)
         w_first = 32'd8;
      else if (32'(r_skip) > w_base)
         w_first = 32'(r_skip) - w_base;
      else
         w_first = 32'd0;
      w_nwr = w_data_beat ? 4'(32'd8 - w_first) : 4'd0;
   end

   // Fetch FSM next state plus pointer, occupancy and target bookkeeping.
   always_comb begin
      w_state_nxt    = r_state;
      w_beat_nxt     = r_beat;
      w_line_nxt     = r_fetch_line;
      w_skip_nxt     = r_skip;
      case (r_state)
         S_IDLE: begin
            if (w_req_fire) begin
               w_state_nxt = redirect ? S_DRAIN : S_WAIT;
               w_beat_nxt  = '0;
            end
         end
         S_WAIT, S_ACTIVE: begin
            if (resp_cyc) begin
               if (w_last) begin
                  // Line complete; a coincident redirect leaves nothing to drain.
                  w_state_nxt = S_IDLE;
                  w_beat_nxt  = '0;
                  w_line_nxt  = r_fetch_line + 64'(LINE_BYTES);
                  w_skip_nxt  = '0;
               end else begin
                  w_beat_nxt  = r_beat + c_beat_w'(1);
                  w_state_nxt = redirect ? S_DRAIN : S_ACTIVE;
               end
            end else if (redirect) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (resp_cyc) begin
               if (w_last) begin
                  w_state_nxt = S_IDLE;
                  w_beat_nxt  = '0;
               end else begin
                  w_beat_nxt  = r_beat + c_beat_w'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_wr_nxt       = r_wr + c_ptr_w'(w_nwr);
      w_rd_nxt       = r_rd + c_ptr_w'(w_cons);
      w_occ_nxt      = r_occ + c_occ_w'(w_nwr) - c_occ_w'(w_cons);
      w_win_addr_nxt = r_win_addr + 64'(w_cons);

      if (redirect) begin
         w_wr_nxt       = '0;
         w_rd_nxt       = '0;
         w_occ_nxt      = '0;
         w_win_addr_nxt = redirect_addr;
         w_line_nxt     = {redirect_addr[63:c_loff_w], {c_loff_w{1'b0}}};
         w_skip_nxt     = redirect_addr[c_loff_w-1:0];
      end

      // Request is registered from next-cycle state so it tracks space without lag.
      w_req_cyc_nxt  = (w_state_nxt == S_IDLE) &&
                       (w_occ_nxt <= c_occ_w'(BUF_BYTES - LINE_BYTES));
      w_req_addr_nxt = (w_state_nxt == S_IDLE) ? w_line_nxt : r_req_addr;
   end

   // Control state with asynchronous active-low reset that loads the entry point.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_rd         <= '0;
         r_wr         <= '0;
         r_occ        <= '0;
         r_beat       <= '0;
         r_fetch_line <= {entry[63:c_loff_w], {c_loff_w{1'b0}}};
         r_skip       <= entry[c_loff_w-1:0];
         r_win_addr   <= entry;
         r_req_cyc    <= 1'b0;
         r_req_addr   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_rd         <= w_rd_nxt;
         r_wr         <= w_wr_nxt;
         r_occ        <= w_occ_nxt;
         r_beat       <= w_beat_nxt;
         r_fetch_line <= w_line_nxt;
         r_skip       <= w_skip_nxt;
         r_win_addr   <= w_win_addr_nxt;
         r_req_cyc    <= w_req_cyc_nxt;
         r_req_addr   <= w_req_addr_nxt;
      end
   end

   // Byte storage: write the accepted suffix of a beat contiguously at the write pointer.
   always_ff @(posedge clk) begin
      if (w_data_beat) begin
         for (int k = 0; k < 8; k++) begin
            if (32'(k) >= w_first)
               r_buf[r_wr + c_ptr_w'(32'(k) - w_first)] <= resp_data[8*k +: 8];
         end
      end
   end

   // Decode window wraps across the end of the circular buffer.
   for (genvar gi = 0; gi < WINDOW; gi++) begin : g_win
      assign win_bytes[8*gi +: 8] = r_buf[r_rd + c_ptr_w'(gi)];
   end

   // The decoder may never retire more bytes than the buffer holds.
   a_consume_le_occ: assert property (@(posedge clk) disable iff (!reset)
                                      (c_occ_w'(consume) <= r_occ));

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
//  Module   : tb_fetch_buffer
//  Purpose  : Directed self-checking bench for fetch_buffer with a byte-count
//             model of occupancy/window address and an address-derived memory.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

   logic          clk;
   logic          reset;
   logic [63:0]   entry;
   logic          req_cyc;
   logic [63:0]   req_addr;
   logic          req_ack;
   logic          resp_cyc;
   logic [63:0]   resp_data;
   logic          resp_ack;
   logic          redirect;
   logic [63:0]   redirect_addr;
   logic          win_valid;
   logic [119:0]  win_bytes;
   logic [63:0]   win_addr;
   logic [3:0]    consume;
   logic [7:0]    occupancy;

   int            n_total = 0;
   int            n_fail  = 0;
   bit            track   = 0;
   bit            auto_cons = 0;
   int            exp_occ = 0;
   logic [63:0]   exp_waddr = '0;
   int            beat_wr = 0;
   int            cons_total = 0;

   fetch_buffer dut (
      .clk           (clk),
      .reset         (reset),
      .entry         (entry),
      .req_cyc       (req_cyc),
      .req_addr      (req_addr),
      .req_ack       (req_ack),
      .resp_cyc      (resp_cyc),
      .resp_data     (resp_data),
      .resp_ack      (resp_ack),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .win_valid     (win_valid),
      .win_bytes     (win_bytes),
      .win_addr      (win_addr),
      .consume       (consume),
      .occupancy     (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] memb(input logic [63:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = memb(line + 64'(8*b + k));
      return d;
   endfunction

   function automatic logic [119:0] exp_win(input logic [63:0] a);
      logic [119:0] w;
      for (int i = 0; i < 15; i++) w[8*i +: 8] = memb(a + 64'(i));
      return w;
   endfunction

   function automatic int written(input int b, input int skip);
      int lo;
      lo = 8 * b;
      if (skip >= lo + 8) return 0;
      if (skip > lo) return lo + 8 - skip;
      return 8;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: update the model from the inputs about to be sampled, then check.
   task automatic step();
      int c;
      if (auto_cons) consume = win_valid ? 4'd7 : 4'd0;
      c = (win_valid && !redirect) ? int'(consume) : 0;
      if (redirect) begin
         exp_occ   = 0;
         exp_waddr = redirect_addr;
      end else begin
         exp_occ    = exp_occ + (resp_cyc ? beat_wr : 0) - c;
         exp_waddr  = exp_waddr + 64'(c);
         cons_total = cons_total + c;
      end
      @(posedge clk);
      @(negedge clk);
      if (track) begin
         chk("occupancy", 128'(occupancy), 128'(exp_occ));
         chk("win_addr", 128'(win_addr), 128'(exp_waddr));
         chk("win_valid", 128'(win_valid), 128'(exp_occ >= 15));
         if (exp_occ >= 15) chk("win_bytes", 128'(win_bytes), 128'(exp_win(exp_waddr)));
      end
   endtask

   task automatic get_req(input logic [63:0] addr);
      for (int t = 0; t < 200 && req_cyc !== 1'b1; t++) step();
      chk("req_cyc_wait", 128'(req_cyc), 128'(1));
      chk("req_addr", 128'(req_addr), 128'(addr));
      req_ack = 1'b1;
      step();
      req_ack = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] line, input int b, input int skip,
                            input int maxgap, input bit live);
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) step();
      resp_cyc  = 1'b1;
      resp_data = beat_data(line, b);
      beat_wr   = live ? written(b, skip) : 0;
      #1;
      chk("resp_ack", 128'(resp_ack), 128'(1));
      step();
      resp_cyc = 1'b0;
      beat_wr  = 0;
   endtask

   task automatic serve_line(input logic [63:0] line, input int skip, input int maxgap);
      get_req(line);
      for (int b = 0; b < 8; b++) send_beat(line, b, skip, maxgap, 1'b1);
   endtask

   task automatic do_redirect(input logic [63:0] a);
      redirect      = 1'b1;
      redirect_addr = a;
      step();
      redirect      = 1'b0;
   endtask

   initial begin
      reset = 1'b1; entry = 64'h1000; req_ack = 1'b0; resp_cyc = 1'b0;
      resp_data = '0; redirect = 1'b0; redirect_addr = '0; consume = '0;

      // Reset state, applied without a clock edge.
      #2 reset = 1'b0;
      #1;
      chk("rst_req_cyc", 128'(req_cyc), 128'(0));
      chk("rst_req_addr", 128'(req_addr), 128'(0));
      chk("rst_win_valid", 128'(win_valid), 128'(0));
      chk("rst_occupancy", 128'(occupancy), 128'(0));
      chk("rst_win_addr", 128'(win_addr), 128'(64'h1000));
      exp_occ = 0; exp_waddr = 64'h1000;
      @(negedge clk);
      reset = 1'b1;
      track = 1;

      // Aligned start: request on the first edge, two lines fill the buffer.
      step();
      chk("first_req_cyc", 128'(req_cyc), 128'(1));
      chk("first_req_addr", 128'(req_addr), 128'(64'h1000));
      serve_line(64'h1000, 0, 0);
      chk("line1_occ", 128'(occupancy), 128'(64));
      chk("line1_bytes", 128'(win_bytes), 128'(exp_win(64'h1000)));
      serve_line(64'h1040, 0, 0);
      chk("full_occ", 128'(occupancy), 128'(128));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("full_no_req", 128'(req_cyc), 128'(0));
      end

      // Backpressure release: request returns as soon as a line of space exists.
      consume = 4'd15;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_req_cyc", 128'(req_cyc), 128'(exp_occ <= 64));
      end
      consume = 4'd0;
      chk("bp_occ", 128'(occupancy), 128'(53));
      chk("bp_req_addr", 128'(req_addr), 128'(64'h1080));

      // Redirect while idle with a pending request retargets it.
      do_redirect(64'h2004);
      chk("rdir_idle_req", 128'(req_cyc), 128'(1));
      chk("rdir_idle_addr", 128'(req_addr), 128'(64'h2000));

      // Redirect mid-line: remaining beats are drained without being written.
      get_req(64'h2000);
      for (int b = 0; b < 4; b++) send_beat(64'h2000, b, 4, 0, 1'b1);
      chk("pre_rdir_occ", 128'(occupancy), 128'(28));
      do_redirect(64'h2004);
      for (int b = 4; b < 8; b++) send_beat(64'h2000, b, 4, 0, 1'b0);
      chk("drain_occ", 128'(occupancy), 128'(0));
      serve_line(64'h2000, 4, 0);
      chk("rdir_occ", 128'(occupancy), 128'(60));
      chk("rdir_byte0", 128'(win_bytes[7:0]), 128'(memb(64'h2004)));

      // Wrap: continuous 7-byte consumption with random beat gaps.
      do_redirect(64'h4000);
      auto_cons  = 1;
      cons_total = 0;
      for (int n = 0; n < 16 && cons_total < 600; n++)
         serve_line(64'h4000 + 64'(64*n), 0, 2);
      auto_cons = 0;
      consume   = 4'd0;
      chk("wrap_consumed", 128'(cons_total >= 600), 128'(1));

      // Asynchronous reset in the middle of a line.
      do_redirect(64'h6000);
      get_req(64'h6000);
      for (int b = 0; b < 3; b++) send_beat(64'h6000, b, 0, 0, 1'b1);
      entry = 64'h3000;
      track = 0;
      #2 reset = 1'b0;
      #1;
      chk("arst_req_cyc", 128'(req_cyc), 128'(0));
      chk("arst_occ", 128'(occupancy), 128'(0));
      chk("arst_win_addr", 128'(win_addr), 128'(64'h3000));
      @(negedge clk);
      reset = 1'b1;
      exp_occ = 0; exp_waddr = 64'h3000; track = 1;
      step();
      chk("arst_req", 128'(req_cyc), 128'(1));
      chk("arst_req_addr", 128'(req_addr), 128'(64'h3000));

      // Unaligned entry: leading bytes of the line are skipped.
      entry = 64'h100B;
      track = 0;
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_occ = 0; exp_waddr = 64'h100B; track = 1;
      serve_line(64'h1000, 11, 1);
      chk("unal_occ", 128'(occupancy), 128'(53));
      chk("unal_win_addr", 128'(win_addr), 128'(64'h100B));
      chk("unal_byte0", 128'(win_bytes[7:0]), 128'(memb(64'h100B)));

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised instruction-fetch front end between the core's system bus port and the x86 decoder. It issues line-sized read requests and fills a circular byte buffer from 64-bit response beats, honouring a byte-granular start offset. It presents a sliding WINDOW-byte view to the decoder, which consumes a variable number of bytes per cycle. A redirect flushes the buffer and discards the line in flight, so control-flow changes need no external cleanup.

## Interface
- BUF_BYTES, 128: circular buffer size in bytes; power of 2, ≥ 2*LINE_BYTES.
- LINE_BYTES, 64: bytes per bus read; power of 2, multiple of 8. BEATS = LINE_BYTES/8.
- WINDOW, 15: decoder window in bytes; ≤ LINE_BYTES.
- clk  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low (0 = reset).
- entry  in  64  start address; must be stable while reset is 0.
- req_cyc  out  1  read request valid.
- req_addr  out  64  line-aligned request address.
- req_ack  in  1  bus accepted the request this cycle.
- resp_cyc  in  1  response beat valid.
- resp_data  in  64  response beat; byte k = resp_data[8k+:8].
- resp_ack  out  1  combinational copy of resp_cyc.
- redirect  in  1  one-cycle flush/refetch pulse.
- redirect_addr  in  64  new fetch address.
- win_valid  out  1  occupancy ≥ WINDOW.
- win_bytes  out  WINDOW*8  win_bytes[8i+:8] = byte at win_addr+i.
- win_addr  out  64  address of window byte 0.
- consume  in  $clog2(WINDOW+1)  bytes retired this cycle.
- occupancy  out  $clog2(BUF_BYTES)+1  valid bytes held.

## Operation
- Fetch FSM: IDLE, WAIT, ACTIVE, DRAIN.
- IDLE: req_cyc=1 when BUF_BYTES − occupancy ≥ LINE_BYTES; req_addr = fetch_line. req_cyc/req_addr hold until req_ack. On req_ack → WAIT.
- WAIT: first accepted beat → ACTIVE, beat counter = 1.
- ACTIVE: each beat increments the counter. After beat BEATS−1: fetch_line += LINE_BYTES, skip = 0, → IDLE.
- Skip: skip = start address mod LINE_BYTES. Beats wholly below skip are dropped. In the beat containing the start byte, only bytes at or above skip are written. Later beats write all 8 bytes. The write pointer advances by bytes written, modulo BUF_BYTES.
- Window: read pointer rd indexes the buffer modulo BUF_BYTES; win_bytes wraps across the buffer end.
- Consume: applied only when win_valid=1. rd += consume, win_addr += consume. consume with win_valid=0 is ignored. consume > occupancy is illegal and must fire an assertion.
- Occupancy update: occupancy_next = occupancy + written − consumed; a beat write and a consume in the same cycle both apply.
- Redirect, in every state:
  - Buffer flushes: rd = wr = 0, occupancy = 0.
  - win_addr = redirect_addr; fetch_line = redirect_addr aligned down to LINE_BYTES; skip = redirect_addr mod LINE_BYTES.
  - consume in the same cycle is ignored.
  - In IDLE with no req_ack that cycle: req_addr updates next cycle and no bus state is lost.
  - In IDLE with req_ack that cycle, or in WAIT/ACTIVE: → DRAIN.
- DRAIN: accepts and discards the remaining beats of the stale line, counted by the beat counter. After its last beat → IDLE. A redirect during DRAIN updates only the target.

## Timing
- Reset values (reset=0, immediate, no clock needed):
  - Outputs: req_cyc=0, req_addr=0, win_valid=0, occupancy=0, win_addr=entry.
  - Internal: state=IDLE, rd=wr=0, beat counter=0, fetch_line=entry aligned down, skip=entry mod LINE_BYTES.
- req_cyc is registered: asserted on the first clk edge after reset goes high.
- A beat accepted at edge N is reflected in occupancy, win_valid and win_bytes after edge N; this is 1-cycle latency.
- win_valid is combinational from the occupancy register.
- A consume at edge N is reflected in win_addr and win_bytes after edge N.
- Redirect at edge N: occupancy=0 after N. A new req_cyc can assert after N+1 from IDLE, or after the final DRAIN beat otherwise.
- Beats may arrive with gaps; the counter, not resp_cyc deassertion, ends a line.
- All address arithmetic is mod 2^64; pointers are mod BUF_BYTES.

## Test plan
- Aligned start: entry=0x1000, release reset → req_addr=0x1000 the next cycle. Ack, 8 beats → occupancy=64, win_valid=1, win_bytes match mem[0x1000..0x100E]. The second request 0x1040 issues; a third does not issue before any consume.
- Unaligned start: entry=0x100B → req 0x1000. Beat 0 is dropped and beat 1 writes 5 bytes → occupancy=53 after the line, win_addr=0x100B, win_bytes[7:0]=mem[0x100B].
- Backpressure: no consume → occupancy stops at 128 and req_cyc stays 0. Then consume 15 per cycle → req_cyc rises on the cycle occupancy ≤ 64.
- Redirect mid-line: redirect to 0x2004 after beat 3 → beats 4–7 are discarded and occupancy stays 0. The next req is 0x2000, and win_bytes[7:0]=mem[0x2004] once occupancy ≥ 15.
- Wrap and simultaneous events: consume 7 per cycle over 600 bytes with random beat gaps. The window matches the memory model across every 128-byte wrap, and occupancy equals written − consumed every cycle.
- Async reset: drop reset mid-ACTIVE between clock edges → req_cyc=0 and occupancy=0 immediately. Re-release with entry=0x3000 → first req is 0x3000.
